// File: rtl/ao_rst_ctrl.sv
// Always-on reset sequencer: async-assert / sync-release, staged domain reset release,
// warm-reset handling of soft requests and a sticky reset-cause record.
module ao_rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int POR_CYCLES  = 16,
    parameter int SYS_DLY     = 8,
    parameter int APB1_DLY    = 4,
    parameter int REQ_HOLD    = 32,
    parameter int CNT_W       = 8
) (
    input  logic       sys_root_clk,
    input  logic       sys_root_rst,
    input  logic       sw_rst_req,
    input  logic       wdt_rst_req,
    input  logic       lockup_rst_req,
    input  logic       cause_clr,
    output logic       power_on_rstn,
    output logic       sys_root_rstn,
    output logic       apb1_root_rstn,
    output logic [2:0] rst_cause,
    output logic       rst_busy
);

    typedef enum logic [2:0] {
        SYNC,
        POR_WAIT,
        SYS_REL,
        APB_REL,
        RUN,
        WARM_HOLD
    } state_e;

    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(SYS_DLY - 1);
    localparam logic [CNT_W-1:0] APB1_LAST = CNT_W'(APB1_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REQ_HOLD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rel;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             cause_q, cause_d;
    logic [2:0]             setBits;
    logic                   anyReq;
    logic                   porRstn_q, porRstn_d;
    logic                   sysRstn_q, sysRstn_d;
    logic                   apbRstn_q, apbRstn_d;
    logic                   busy_q, busy_d;

    assign rel    = sync_q[SYNC_STAGES-1];
    assign anyReq = sw_rst_req | wdt_rst_req | lockup_rst_req;

    // Deassertion synchronizer: cleared asynchronously, fills with ones after release.
    always_ff @(posedge sys_root_clk or posedge sys_root_rst) begin
        if (sys_root_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge sys_root_clk or posedge sys_root_rst) begin
        if (sys_root_rst) begin
            state_q   <= SYNC;
            cnt_q     <= '0;
            cause_q   <= 3'b000;
            porRstn_q <= 1'b0;
            sysRstn_q <= 1'b0;
            apbRstn_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            porRstn_q <= porRstn_d;
            sysRstn_q <= sysRstn_d;
            apbRstn_q <= apbRstn_d;
            busy_q    <= busy_d;
        end
    end

    // Each timed state leaves on the cycle its counter reaches the last count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            SYNC:      if (rel) state_d = POR_WAIT;
            POR_WAIT:  if (cnt_q == POR_LAST) state_d = SYS_REL;
            SYS_REL:   if (cnt_q == SYS_LAST) state_d = APB_REL;
            APB_REL:   if (cnt_q == APB1_LAST) state_d = RUN;
            RUN:       if (anyReq) state_d = WARM_HOLD;
            WARM_HOLD: if (cnt_q == HOLD_LAST) state_d = SYS_REL;
            default:   state_d = SYNC;
        endcase
        if (state_d != state_q || state_q == SYNC || state_q == RUN) begin
            cnt_d = '0;
        end
    end

    // Requests only count in RUN; a clear drops every bit not being set on the same edge.
    always_comb begin
        setBits = 3'b000;
        if (state_q == RUN) begin
            setBits = {lockup_rst_req, wdt_rst_req, sw_rst_req};
        end
        cause_d = cause_clr ? setBits : (cause_q | setBits);
    end

    // Outputs decoded from the next state so they change on the transition edge itself.
    always_comb begin
        porRstn_d = state_d inside {SYS_REL, APB_REL, RUN, WARM_HOLD};
        sysRstn_d = state_d inside {APB_REL, RUN};
        apbRstn_d = (state_d == RUN);
        busy_d    = (state_d != RUN);
    end

    assign power_on_rstn  = porRstn_q;
    assign sys_root_rstn  = sysRstn_q;
    assign apb1_root_rstn = apbRstn_q;
    assign rst_cause      = cause_q;
    assign rst_busy       = busy_q;

endmodule

// File: tb/tb_ao_rst_ctrl.sv
// Directed self-checking bench for ao_rst_ctrl with default parameters.
// Observed vector layout: {power_on_rstn, sys_root_rstn, apb1_root_rstn, rst_busy, rst_cause[2:0]}.
module tb_ao_rst_ctrl;

    logic       sys_root_clk = 1'b0;
    logic       sys_root_rst = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       wdt_rst_req = 1'b0;
    logic       lockup_rst_req = 1'b0;
    logic       cause_clr = 1'b0;
    logic       power_on_rstn;
    logic       sys_root_rstn;
    logic       apb1_root_rstn;
    logic [2:0] rst_cause;
    logic       rst_busy;

    int testCount = 0;
    int failCount = 0;

    ao_rst_ctrl dut (
        .sys_root_clk  (sys_root_clk),
        .sys_root_rst  (sys_root_rst),
        .sw_rst_req    (sw_rst_req),
        .wdt_rst_req   (wdt_rst_req),
        .lockup_rst_req(lockup_rst_req),
        .cause_clr     (cause_clr),
        .power_on_rstn (power_on_rstn),
        .sys_root_rstn (sys_root_rstn),
        .apb1_root_rstn(apb1_root_rstn),
        .rst_cause     (rst_cause),
        .rst_busy      (rst_busy)
    );

    always #5 sys_root_clk = ~sys_root_clk;

    function automatic logic [6:0] observe();
        return {power_on_rstn, sys_root_rstn, apb1_root_rstn, rst_busy, rst_cause};
    endfunction

    task automatic test_reset();
        logic [6:0] obs;
        #1 sys_root_rst = 1'b1;
        #2;
        obs = observe();
        testCount++;
        if (obs !== 7'b0001000) begin
            failCount++;
            $display("[TB] FAIL reset_async: got %b expected %b", obs, 7'b0001000);
        end
        repeat (3) @(posedge sys_root_clk);
        #1;
        obs = observe();
        testCount++;
        if (obs !== 7'b0001000) begin
            failCount++;
            $display("[TB] FAIL reset_held: got %b expected %b", obs, 7'b0001000);
        end
    endtask

    task automatic test_cold_boot();
        logic [6:0] obs, exp;
        @(negedge sys_root_clk);
        sys_root_rst = 1'b0;
        for (int k = 0; k <= 35; k++) begin
            @(posedge sys_root_clk);
            #1;
            obs = observe();
            exp = {k >= 18, k >= 26, k >= 30, k < 30, 3'b000};
            testCount++;
            if (obs !== exp) begin
                failCount++;
                $display("[TB] FAIL cold_boot edge %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_async_abort();
        logic [6:0] obs, exp;
        @(negedge sys_root_clk);
        sys_root_rst = 1'b1;
        #2 sys_root_rst = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            @(posedge sys_root_clk);
            #1;
            obs = observe();
            exp = {k >= 18, k >= 26, k >= 30, k < 30, 3'b000};
            testCount++;
            if (obs !== exp) begin
                failCount++;
                $display("[TB] FAIL abort_pre edge %0d: got %b expected %b", k, obs, exp);
            end
        end
        #1 sys_root_rst = 1'b1;
        #1;
        obs = observe();
        testCount++;
        if (obs !== 7'b0001000) begin
            failCount++;
            $display("[TB] FAIL abort_async: got %b expected %b", obs, 7'b0001000);
        end
        #2 sys_root_rst = 1'b0;
        for (int k = 0; k <= 31; k++) begin
            @(posedge sys_root_clk);
            #1;
            obs = observe();
            exp = {k >= 18, k >= 26, k >= 30, k < 30, 3'b000};
            testCount++;
            if (obs !== exp) begin
                failCount++;
                $display("[TB] FAIL abort_replay edge %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_warm_reset();
        logic [6:0] obs, exp;
        wdt_rst_req = 1'b1;
        for (int i = 1; i <= 46; i++) begin
            @(posedge sys_root_clk);
            #1;
            if (i == 1) wdt_rst_req = 1'b0;
            obs = observe();
            exp = {1'b1, i >= 41, i >= 45, i < 45, 3'b010};
            testCount++;
            if (obs !== exp) begin
                failCount++;
                $display("[TB] FAIL warm_reset N+%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [6:0] obs;
        cause_clr = 1'b1;
        @(posedge sys_root_clk);
        #1 cause_clr = 1'b0;
        obs = observe();
        testCount++;
        if (obs !== 7'b1110000) begin
            failCount++;
            $display("[TB] FAIL clr_before: got %b expected %b", obs, 7'b1110000);
        end
        sw_rst_req = 1'b1;
        lockup_rst_req = 1'b1;
        @(posedge sys_root_clk);
        #1 sw_rst_req = 1'b0;
        lockup_rst_req = 1'b0;
        obs = observe();
        testCount++;
        if (obs !== 7'b1001101) begin
            failCount++;
            $display("[TB] FAIL simul_set: got %b expected %b", obs, 7'b1001101);
        end
        repeat (44) @(posedge sys_root_clk);
        #1;
        obs = observe();
        testCount++;
        if (obs !== 7'b1110101) begin
            failCount++;
            $display("[TB] FAIL simul_return: got %b expected %b", obs, 7'b1110101);
        end
        cause_clr = 1'b1;
        @(posedge sys_root_clk);
        #1 cause_clr = 1'b0;
        obs = observe();
        testCount++;
        if (obs !== 7'b1110000) begin
            failCount++;
            $display("[TB] FAIL clr_run: got %b expected %b", obs, 7'b1110000);
        end
        cause_clr = 1'b1;
        sw_rst_req = 1'b1;
        @(posedge sys_root_clk);
        #1 cause_clr = 1'b0;
        sw_rst_req = 1'b0;
        obs = observe();
        testCount++;
        if (obs !== 7'b1001001) begin
            failCount++;
            $display("[TB] FAIL clr_with_set: got %b expected %b", obs, 7'b1001001);
        end
        repeat (44) @(posedge sys_root_clk);
        #1;
        obs = observe();
        testCount++;
        if (obs !== 7'b1110001) begin
            failCount++;
            $display("[TB] FAIL clr_set_return: got %b expected %b", obs, 7'b1110001);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] obs, exp;
        logic       apbExp, sysExp;
        wdt_rst_req = 1'b1;
        for (int i = 1; i <= 91; i++) begin
            @(posedge sys_root_clk);
            #1;
            apbExp = (i == 45) || (i == 90) || (i == 91);
            sysExp = (i >= 41 && i <= 45) || (i >= 86);
            obs = observe();
            exp = {1'b1, sysExp, apbExp, !apbExp, 3'b011};
            testCount++;
            if (obs !== exp) begin
                failCount++;
                $display("[TB] FAIL back_to_back N+%0d: got %b expected %b", i, obs, exp);
            end
            if (i == 90) wdt_rst_req = 1'b0;
        end
    endtask

    task automatic test_ignored_request();
        logic [6:0] obs, exp;
        @(negedge sys_root_clk);
        sys_root_rst = 1'b1;
        #2 sys_root_rst = 1'b0;
        for (int k = 0; k <= 35; k++) begin
            @(posedge sys_root_clk);
            #1;
            obs = observe();
            exp = {k >= 18, k >= 26, k >= 30, k < 30, 3'b000};
            testCount++;
            if (obs !== exp) begin
                failCount++;
                $display("[TB] FAIL ignored_req edge %0d: got %b expected %b", k, obs, exp);
            end
            if (k == 20) sw_rst_req = 1'b1;
            if (k == 21) sw_rst_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_cold_boot();
        test_async_abort();
        test_warm_reset();
        test_simultaneous();
        test_back_to_back();
        test_ignored_request();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
